// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider - sequential 32-bit restoring radix-2 integer divider.
//
// One quotient bit per cycle; stall is high for 33 cycles (load + 32 steps),
// and the result is valid in the cycle where stall first drops with run
// still high. Signed dividends (u=1) give floored division, so the
// remainder always satisfies 0 <= rem < y. The divisor is always unsigned.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   run    in   held high for the whole divide
//   u      in   1 = signed dividend (floored), 0 = unsigned
//   x      in   [31:0] dividend, stable while run is high
//   y      in   [31:0] divisor, stable while run is high
//   stall  out  high while the division is in progress
//   quot   out  [31:0] quotient
//   rem    out  [31:0] remainder
// ---------------------------------------------------------------------------
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        u,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        stall,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    localparam logic [5:0] LAST = 6'd33;

    logic [5:0]  s;
    logic [63:0] rq;
    logic        neg;
    logic [31:0] xa;
    logic [31:0] r;
    logic [32:0] d;

    // The magnitude of a negative dividend is divided, then the result is
    // folded back into floored form on the output side.
    assign neg = u & x[31];
    assign xa  = neg ? -x : x;

    // Trial subtraction of the divisor from the shifted partial remainder;
    // d[32] set means the subtraction borrowed and the step restores.
    assign r = rq[62:31];
    assign d = {1'b0, r} - {1'b0, y};

    assign stall = run & (s != LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            s  <= '0;
            rq <= '0;
        end else if (!run) begin
            s <= '0;
        end else if (s != LAST) begin
            s <= s + 6'd1;
            if (s == 6'd0)
                rq <= {32'b0, xa};
            else
                rq <= {(d[32] ? r : d[31:0]), rq[30:0], ~d[32]};
        end
    end

    // Floored correction: a non-zero remainder on a negative dividend pulls
    // the quotient down by one and reflects the remainder into [0, y).
    // -q - 1 is the bitwise complement of q.
    always_comb begin
        quot = rq[31:0];
        rem  = rq[63:32];
        if (neg) begin
            if (rq[63:32] == 32'd0) begin
                quot = -rq[31:0];
                rem  = 32'd0;
            end else begin
                quot = ~rq[31:0];
                rem  = y - rq[63:32];
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
module tb_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        u   = 1'b0;
    logic [31:0] x   = '0;
    logic [31:0] y   = '0;
    logic        stall;
    logic [31:0] quot;
    logic [31:0] rem;

    int n_tests = 0;
    int n_fail  = 0;

    divider dut (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .u    (u),
        .x    (x),
        .y    (y),
        .stall(stall),
        .quot (quot),
        .rem  (rem)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic; floored for signed dividends, and the
    // unsigned divide-by-zero convention (all-ones quotient, rem = x).
    function automatic void ref_div(input logic su, input logic [31:0] sx,
                                    input logic [31:0] sy,
                                    output logic [31:0] q, output logic [31:0] r);
        longint xs, ys, qq, rr;
        if (sy == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = sx;
        end else begin
            xs = su ? longint'($signed(sx)) : longint'({32'b0, sx});
            ys = longint'({32'b0, sy});
            qq = xs / ys;
            rr = xs % ys;
            if (rr < 0) begin
                qq = qq - 1;
                rr = rr + ys;
            end
            q = qq[31:0];
            r = rr[31:0];
        end
    endfunction

    // Stimulus only: raises run with the operands at mid-cycle, counts the
    // stall cycles (bounded) and returns the outputs seen in the done cycle.
    // run is left high; the caller decides when to drop it.
    task automatic start_div(input logic su, input logic [31:0] sx,
                             input logic [31:0] sy, output int cyc,
                             output logic [31:0] q, output logic [31:0] r);
        @(negedge clk);
        u = su; x = sx; y = sy; run = 1'b1;
        #1;
        cyc = 0;
        while (stall && cyc < 100) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        q = quot;
        r = rem;
    endtask

    task automatic finish_div();
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b0; u = 1'b0; x = 32'hDEAD_BEEF; y = 32'd5;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (quot !== 32'd0 || rem !== 32'd0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: quot=%h rem=%h stall=%b required 0 0 0", quot, rem, stall);
        end
        run = 1'b1;
        #1;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_stall_eq_run: stall=%b required 1", stall);
        end
        @(negedge clk);
        run = 1'b0; rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] tx[6] = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF8, 32'h7FFF_FFFF, 32'h1234_5678};
        logic [31:0] ty[6] = '{32'd7, 32'h10, 32'd2, 32'd2, 32'd3, 32'd0};
        logic        tu[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] eq[6] = '{32'd14, 32'h0FFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h2AAA_AAAA, 32'hFFFF_FFFF};
        logic [31:0] er[6] = '{32'd2, 32'hF, 32'd1, 32'd0, 32'd1, 32'h1234_5678};
        int cyc;
        logic [31:0] q, r;
        for (int i = 0; i < 6; i++) begin
            start_div(tu[i], tx[i], ty[i], cyc, q, r);
            finish_div();
            n_tests++;
            if (cyc !== 33 || q !== eq[i] || r !== er[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: stall=%0d quot=%h rem=%h required 33 %h %h",
                         i, cyc, q, r, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        logic su;
        logic [31:0] sx, sy, q, r, eq, er;
        for (int i = 0; i < 40; i++) begin
            su = (i >= 20);
            sx = $urandom;
            sy = (i % 4 == 0) ? ($urandom_range(1, 300)) : $urandom;
            if (su) sy[31] = 1'b0;
            if (sy == 32'd0) sy = 32'd1;
            ref_div(su, sx, sy, eq, er);
            start_div(su, sx, sy, cyc, q, r);
            finish_div();
            n_tests++;
            if (cyc !== 33 || q !== eq || r !== er) begin
                n_fail++;
                $display("FAIL random_%0d u=%b x=%h y=%h: stall=%0d quot=%h rem=%h required 33 %h %h",
                         i, su, sx, sy, cyc, q, r, eq, er);
            end
        end
    endtask

    task automatic test_hold();
        int cyc;
        logic [31:0] q, r, eq, er;
        ref_div(1'b1, 32'hFFFF_F000, 32'd13, eq, er);
        start_div(1'b1, 32'hFFFF_F000, 32'd13, cyc, q, r);
        n_tests++;
        if (cyc !== 33 || q !== eq || r !== er) begin
            n_fail++;
            $display("FAIL hold_done: stall=%0d quot=%h rem=%h required 33 %h %h", cyc, q, r, eq, er);
        end
        for (int k = 34; k < 40; k++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (stall !== 1'b0 || quot !== eq || rem !== er) begin
                n_fail++;
                $display("FAIL hold_cycle_%0d: stall=%b quot=%h rem=%h required 0 %h %h",
                         k, stall, quot, rem, eq, er);
            end
        end
        finish_div();
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [31:0] q, r, eq, er;
        start_div(1'b0, 32'd1000, 32'd9, cyc, q, r);
        finish_div();   // exactly one cycle of run low before the next start
        ref_div(1'b0, 32'hABCD_0123, 32'd77, eq, er);
        start_div(1'b0, 32'hABCD_0123, 32'd77, cyc, q, r);
        finish_div();
        n_tests++;
        if (cyc !== 33 || q !== eq || r !== er) begin
            n_fail++;
            $display("FAIL back_to_back: stall=%0d quot=%h rem=%h required 33 %h %h", cyc, q, r, eq, er);
        end
    endtask

    task automatic test_abort();
        int cyc;
        logic [31:0] q, r, eq, er;
        @(negedge clk);
        u = 1'b0; x = 32'h0F0F_0F0F; y = 32'd3; run = 1'b1;
        repeat (10) @(negedge clk);
        run = 1'b0;
        ref_div(1'b1, 32'h8000_0000, 32'd7, eq, er);
        start_div(1'b1, 32'h8000_0000, 32'd7, cyc, q, r);
        finish_div();
        n_tests++;
        if (cyc !== 33 || q !== eq || r !== er) begin
            n_fail++;
            $display("FAIL abort_restart: stall=%0d quot=%h rem=%h required 33 %h %h", cyc, q, r, eq, er);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [31:0] eq, er;
        ref_div(1'b0, 32'd123456789, 32'd1000, eq, er);
        @(negedge clk);
        u = 1'b0; x = 32'd123456789; y = 32'd1000; run = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (stall !== 1'b1 || quot !== 32'd0 || rem !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: stall=%b quot=%h rem=%h required 1 0 0", stall, quot, rem);
        end
        cyc = 0;
        while (stall && cyc < 100) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        n_tests++;
        if (cyc !== 33 || quot !== eq || rem !== er) begin
            n_fail++;
            $display("FAIL reset_mid_restart: stall=%0d quot=%h rem=%h required 33 %h %h",
                     cyc, quot, rem, eq, er);
        end
        finish_div();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
